change_dispenser_ctrl: RTL and testbench
========================================

CHANGE_DISPENSER_CTRL -- requirements
Module: change_dispenser_ctrl

Interface
REQ-001 SHALL have parameters: TIMEOUT_CYCLES, default 1000000, max cycles a hopper is driven while waiting for its coin sensor; GAP_CYCLES, default 1000, idle cycles between successive coins; INIT_COUNT, default 20, coins per hopper after reset or refill.
REQ-002 SHALL have ports: clk input 1, system clock; reset_n input 1, asynchronous active-low reset.
REQ-003 SHALL have ports: start input 1, one-cycle request pulse; change_amt input 8, change owed in cents, unsigned.
REQ-004 SHALL have ports: coin_sensed input 3, one-cycle sensor pulses, bit 2 = 25c, bit 1 = 10c, bit 0 = 5c; refill input 1, one-cycle hopper restock pulse.
REQ-005 SHALL have ports: hopper_en output 3, motor drives in the same bit order as coin_sensed; busy output 1; done output 1; error output 1; remaining output 8, cents still owed; empty output 3, per-hopper empty flags.

Function
REQ-006 SHALL implement states IDLE, SELECT, DRIVE, GAP, FINISH, with FINISH lasting one cycle before returning to IDLE.
REQ-007 In IDLE, start=1 SHALL latch change_amt into remaining, clear error, and enter SELECT on the next cycle; start SHALL be ignored in every other state.
REQ-008 SELECT SHALL pick greedily among available hoppers: 25 if remaining>=25, else 10 if remaining>=10, else 5 if remaining>=5, then enter DRIVE.
REQ-009 In SELECT, remaining<5 SHALL go to FINISH with error=0; a residual 1-4 cents SHALL stay visible on remaining.
REQ-010 In SELECT, remaining>=5 with no usable hopper SHALL go to FINISH with error=1.
REQ-011 DRIVE SHALL assert exactly one hopper_en bit, the selected one, and reset a timeout counter on entry.
REQ-012 In DRIVE, a coin_sensed pulse on the selected bit SHALL subtract that coin's value from remaining, deassert hopper_en, and enter GAP on the next cycle.
REQ-013 In DRIVE, coin_sensed pulses on non-selected bits SHALL be ignored.
REQ-014 In DRIVE, after TIMEOUT_CYCLES cycles without a sensor pulse, the block SHALL go to FINISH with error=1 and remaining unchanged; a sensor pulse in the expiry cycle SHALL count as success.
REQ-015 GAP SHALL last exactly GAP_CYCLES cycles with hopper_en=0, then return to SELECT.
REQ-016 busy SHALL be 1 in SELECT, DRIVE and GAP, and 0 in IDLE and FINISH.
REQ-017 done SHALL be 1 only in FINISH, a single-cycle pulse.
REQ-018 error SHALL be sticky until the next accepted start or reset.
REQ-019 hopper_en SHALL be 0 in every state except DRIVE.
REQ-020 remaining arithmetic SHALL be 8-bit unsigned and never underflow, which the selection rule guarantees.

Reset
REQ-021 reset_n=0 SHALL asynchronously force IDLE, with hopper_en=0, busy=0, done=0, error=0, remaining=0, timers=0.
REQ-022 reset_n=0 SHALL set every inventory count to INIT_COUNT when CHANGE_INVENTORY_EN is defined.
REQ-023 Reset during DRIVE SHALL deassert hopper_en immediately, without waiting for a clock edge.

Configuration
REQ-024 The macro CHANGE_INVENTORY_EN SHALL select per-hopper inventory tracking.
REQ-025 With CHANGE_INVENTORY_EN defined, each hopper SHALL keep an 8-bit count that decrements on each successful coin.
REQ-026 With CHANGE_INVENTORY_EN defined, a hopper with count 0 SHALL be unusable in SELECT and its empty bit SHALL be 1.
REQ-027 With CHANGE_INVENTORY_EN defined, refill=1 while in IDLE SHALL reload all counts to INIT_COUNT; refill in any other state SHALL be ignored.
REQ-028 Without CHANGE_INVENTORY_EN, all hoppers SHALL always be usable, empty SHALL be tied to 0, and refill SHALL be ignored; the port list SHALL be identical in both builds.

Verification
REQ-029 Test: TIMEOUT_CYCLES=20, GAP_CYCLES=4, start with change_amt=40, sensor pulse 3 cycles into each DRIVE -> hopper_en sequence 100, 010, 001; remaining 40, 15, 5, 0; one done pulse; error=0.
REQ-030 Test: start with change_amt=0 -> done pulse 2 cycles after start; hopper_en never asserted; error=0.
REQ-031 Test: start with change_amt=25, no sensor pulse -> hopper_en=100 for exactly 20 cycles, then done with error=1 and remaining=25.
REQ-032 Test: change_amt=10, coin_sensed=001 during a 010 drive, then 010 -> only the 010 pulse counted; remaining goes to 0.
REQ-033 Test: CHANGE_INVENTORY_EN, INIT_COUNT=1, change_amt=50 -> one 25c coin, then 10c, 10c unavailable after first... sequence 25, 10, 5, then error=1 with remaining=10 and empty=111; after refill in IDLE, empty=000.
REQ-034 Test: reset_n pulled low mid-DRIVE -> hopper_en drops to 0 asynchronously; after reset release, a start is accepted normally.

Source files
------------

// File: rtl/change_dispenser_ctrl.sv
// rtl/change_dispenser_ctrl.sv - greedy coin-change dispenser controller; CHANGE_INVENTORY_EN adds per-hopper inventory
module change_dispenser_ctrl #(
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int GAP_CYCLES     = 1000,
    parameter int INIT_COUNT     = 20
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic [7:0] change_amt,
    input  logic [2:0] coin_sensed,
    input  logic       refill,
    output logic [2:0] hopper_en,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [7:0] remaining,
    output logic [2:0] empty
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [GW-1:0] G_LAST = GW'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        DRIVE,
        GAP,
        FINISH
    } state_t;

    state_t        state, state_d;
    logic [2:0]    sel;
    logic [7:0]    rem;
    logic          err;
    logic [TW-1:0] tcnt;
    logic [GW-1:0] gcnt;
    logic [2:0]    avail;
    logic [2:0]    pick;
    logic [7:0]    coin_val;
    logic          hit;

`ifdef CHANGE_INVENTORY_EN
    logic [7:0] inv [3];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 3; i++) inv[i] <= 8'(INIT_COUNT);
        end else if (state == IDLE && refill) begin
            for (int i = 0; i < 3; i++) inv[i] <= 8'(INIT_COUNT);
        end else if (state == DRIVE && hit) begin
            for (int i = 0; i < 3; i++) begin
                if (sel[i]) inv[i] <= inv[i] - 8'd1;
            end
        end
    end

    always_comb begin
        empty = 3'b000;
        for (int i = 0; i < 3; i++) empty[i] = (inv[i] == 8'd0);
    end
    assign avail = ~empty;
`else
    logic [8:0] unused_cfg;
    assign unused_cfg = {refill, 8'(INIT_COUNT)};
    assign empty      = 3'b000;
    assign avail      = 3'b111;
`endif

    // Largest usable coin that still fits in what is owed.
    always_comb begin
        pick = 3'b000;
        if (avail[2] && rem >= 8'd25)      pick = 3'b100;
        else if (avail[1] && rem >= 8'd10) pick = 3'b010;
        else if (avail[0] && rem >= 8'd5)  pick = 3'b001;
    end

    always_comb begin
        case (sel)
            3'b100:  coin_val = 8'd25;
            3'b010:  coin_val = 8'd10;
            default: coin_val = 8'd5;
        endcase
    end

    assign hit = |(coin_sensed & sel);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_d;
    end

    always_comb begin
        state_d   = state;
        hopper_en = 3'b000;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_d = SELECT;
            end
            SELECT: begin
                busy = 1'b1;
                if (rem < 8'd5 || pick == 3'b000) state_d = FINISH;
                else                             state_d = DRIVE;
            end
            DRIVE: begin
                busy      = 1'b1;
                hopper_en = sel;
                if (hit)                 state_d = GAP;
                else if (tcnt == T_LAST) state_d = FINISH;
            end
            GAP: begin
                busy = 1'b1;
                if (gcnt == G_LAST) state_d = SELECT;
            end
            FINISH: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sel  <= 3'b000;
            rem  <= 8'd0;
            err  <= 1'b0;
            tcnt <= '0;
            gcnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        rem <= change_amt;
                        err <= 1'b0;
                    end
                end
                SELECT: begin
                    sel  <= pick;
                    tcnt <= '0;
                    if (rem >= 8'd5 && pick == 3'b000) err <= 1'b1;
                end
                DRIVE: begin
                    // A pulse in the expiry cycle wins over the timeout.
                    if (hit) begin
                        rem  <= rem - coin_val;
                        gcnt <= '0;
                    end else if (tcnt == T_LAST) begin
                        err <= 1'b1;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                GAP: begin
                    gcnt <= gcnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign remaining = rem;
    assign error     = err;

endmodule

// File: tb/tb_change_dispenser_ctrl.sv
// tb/tb_change_dispenser_ctrl.sv - randomized bench for change_dispenser_ctrl against a transaction-level change model
module tb_change_dispenser_ctrl;

    localparam int TO   = 20;
    localparam int GAP  = 4;
    localparam int INIT = 1;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start;
    logic [7:0] change_amt;
    logic [2:0] coin_sensed;
    logic       refill;
    logic [2:0] hopper_en;
    logic       busy;
    logic       done;
    logic       error;
    logic [7:0] remaining;
    logic [2:0] empty;

    int n_checks = 0;
    int n_errors = 0;

    int m;
    int m_err;
    int exp_busy;
    int inv[3];

    change_dispenser_ctrl #(
        .TIMEOUT_CYCLES(TO),
        .GAP_CYCLES(GAP),
        .INIT_COUNT(INIT)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .start(start),
        .change_amt(change_amt),
        .coin_sensed(coin_sensed),
        .refill(refill),
        .hopper_en(hopper_en),
        .busy(busy),
        .done(done),
        .error(error),
        .remaining(remaining),
        .empty(empty)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int value_of(input int i);
        return (i == 2) ? 25 : (i == 1) ? 10 : 5;
    endfunction

    function automatic bit usable(input int i);
`ifdef CHANGE_INVENTORY_EN
        return inv[i] > 0;
`else
        return 1'b1;
`endif
    endfunction

    function automatic int model_pick();
        for (int i = 2; i >= 0; i--) begin
            if (m >= value_of(i) && usable(i)) return i;
        end
        return -1;
    endfunction

    function automatic logic [2:0] exp_empty();
        logic [2:0] e;
        e = 3'b000;
`ifdef CHANGE_INVENTORY_EN
        for (int i = 0; i < 3; i++) e[i] = (inv[i] == 0);
`endif
        return e;
    endfunction

    function automatic void model_restock();
`ifdef CHANGE_INVENTORY_EN
        for (int i = 0; i < 3; i++) inv[i] = INIT;
`endif
    endfunction

    task automatic do_refill();
        @(negedge clk);
        refill = 1'b1;
        model_restock();
        @(negedge clk);
        refill = 1'b0;
        check("empty_after_refill", empty, exp_empty());
    endtask

    // mode 0 random, 1 fixed delay 3, 2 never sense, 3 fixed delay 3 with wrong-bit noise
    task automatic run_txn(input int amt, input int mode);
        int cyc, busy_cnt, didx, d, pk, pk2;
        bit in_drive, to, noise, fin, timed;
        logic [2:0] sel_bits;
        @(negedge clk);
        start      = 1'b1;
        change_amt = 8'(amt);
        m = amt; m_err = 0; exp_busy = 0;
        cyc = 0; busy_cnt = 0; in_drive = 0; fin = 0; timed = 0;
        didx = 0; d = 0; pk = -1; to = 0; noise = 0; sel_bits = 3'b000;
        @(negedge clk);
        cyc = 1;
        while (!fin && cyc < 3000) begin
            start = 1'b0; coin_sensed = 3'b000; refill = 1'b0;
            if (cyc == 1) begin
                check("latched_amt", remaining, amt);
                check("error_cleared", error, 0);
            end
            if (busy) busy_cnt++;
            if (hopper_en != 3'b000) begin
                if (!in_drive) begin
                    in_drive = 1; didx = 0;
                    pk = model_pick();
                    exp_busy += 1;
                    sel_bits = (pk >= 0) ? 3'(1 << pk) : 3'b000;
                    check("drive_coin", hopper_en, sel_bits);
                    case (mode)
                        1: begin to = 0; d = 3; noise = 0; end
                        2: begin to = 1; d = 0; noise = 0; end
                        3: begin to = 0; d = 3; noise = 1; end
                        default: begin
                            to    = ($urandom_range(0, 9) == 0);
                            d     = ($urandom_range(0, 4) == 0) ? TO - 1 : int'($urandom_range(0, 3));
                            noise = $urandom_range(0, 1) == 1;
                        end
                    endcase
                end else begin
                    didx++;
                    check("drive_hold", hopper_en, sel_bits);
                end
                if (!to && didx == d)  coin_sensed = sel_bits;
                else if (mode == 3)    coin_sensed = ~sel_bits;
                else if (noise)        coin_sensed = 3'($urandom) & ~sel_bits;
            end else if (in_drive) begin
                in_drive = 0;
                check("drive_len", didx + 1, to ? TO : d + 1);
                if (to) begin
                    m_err = 1; exp_busy += TO; timed = 1;
                end else if (pk >= 0) begin
                    m -= value_of(pk);
`ifdef CHANGE_INVENTORY_EN
                    inv[pk]--;
`endif
                    exp_busy += d + 1 + GAP;
                end
            end
            if (done) begin
                if (!timed) begin
                    pk2 = model_pick();
                    check("no_coin_left", pk2 < 0, 1);
                    if (m >= 5) m_err = 1;
                    exp_busy += 1;
                end
                check("busy_cycles", busy_cnt, exp_busy);
                check("done_cycle", cyc, exp_busy + 1);
                check("remaining", remaining, m);
                check("error", error, m_err);
                check("empty", empty, exp_empty());
                fin = 1;
            end else begin
                if (busy && mode == 0 && $urandom_range(0, 7) == 0) begin
                    start = 1'b1; change_amt = 8'($urandom);
                end
                if (busy && $urandom_range(0, 7) == 0) refill = 1'b1;
                @(negedge clk);
                cyc++;
            end
        end
        if (!fin) check("done_seen", 0, 1);
        start = 1'b0; coin_sensed = 3'b000; refill = 1'b0;
        @(negedge clk);
        check("done_single", done, 0);
        check("idle_not_busy", busy, 0);
        check("idle_no_drive", hopper_en, 0);
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; change_amt = 8'd0; coin_sensed = 3'b000; refill = 1'b0;
        for (int i = 0; i < 3; i++) inv[i] = INIT;
        repeat (3) @(negedge clk);
        check("rst_hopper", hopper_en, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_remaining", remaining, 0);
        check("rst_empty", empty, exp_empty());
        reset_n = 1'b1;

        run_txn(40, 1);
        run_txn(0, 1);
        run_txn(25, 2);
        do_refill();
        run_txn(10, 3);
        do_refill();
        run_txn(50, 1);
        do_refill();

        // Reset mid-drive must kill the motor before any clock edge.
        @(negedge clk);
        start = 1'b1; change_amt = 8'd30;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("pre_reset_drive", hopper_en, 3'b100);
        #2 reset_n = 1'b0;
        #1;
        check("async_hopper_off", hopper_en, 0);
        check("async_busy_off", busy, 0);
        check("async_remaining", remaining, 0);
        @(negedge clk);
        reset_n = 1'b1;
        model_restock();
        check("post_reset_empty", empty, exp_empty());
        run_txn(15, 1);

        for (int t = 0; t < 30; t++) begin
            if ($urandom_range(0, 1) == 1) do_refill();
            run_txn(int'($urandom_range(0, 255)), 0);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
